// File: rtl/dma_pkg.sv
// dma_pkg: widths, word types and FSM/mode encodings shared by the copy engine.
package dma_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LEN_W = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_WRITE, ST_FILL, ST_DONE} dma_state_t;
  typedef enum logic {MODE_COPY, MODE_FILL} dma_mode_t;
  // Walk downwards only when the destination starts inside the source block.
  function automatic logic is_desc(addr_t src, addr_t dst, len_t len);
    addr_t delta;
    delta = dst - src;
    return (delta != '0) && (len_t'(delta) < len);
  endfunction
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: datamem-port DMA running overlap-safe block copies and block fills.
module mem_copy_engine
  import dma_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  xfer_count,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);
  dma_state_t state, state_nx;
  addr_t src_cur, dst_cur;
  len_t rem;
  data_t buffer, fill_reg;
  logic desc, last, start_desc;
  assign last = rem == len_t'(1);
  assign start_desc = (dma_mode_t'(mode) == MODE_COPY) && is_desc(src_addr, dst_addr, length);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (length == '0) ? ST_DONE :
                                      (dma_mode_t'(mode) == MODE_FILL) ? ST_FILL : ST_READ;
      ST_READ:  state_nx = abort ? ST_DONE : ST_WRITE;
      ST_WRITE: state_nx = (abort || last) ? ST_DONE : ST_READ;
      ST_FILL:  state_nx = (abort || last) ? ST_DONE : ST_FILL;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      src_cur <= '0;
      dst_cur <= '0;
      rem <= '0;
      buffer <= '0;
      fill_reg <= '0;
      desc <= 1'b0;
      xfer_count <= '0;
      aborted <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          xfer_count <= '0;
          aborted <= 1'b0;
          fill_reg <= fill_value;
          rem <= length;
          desc <= start_desc;
          src_cur <= start_desc ? src_addr + addr_t'(length) - addr_t'(1) : src_addr;
          dst_cur <= start_desc ? dst_addr + addr_t'(length) - addr_t'(1) : dst_addr;
        end
        ST_READ: if (abort) aborted <= 1'b1;
                 else buffer <= mem_read_data;
        ST_WRITE, ST_FILL: if (abort) aborted <= 1'b1;
        else begin
          xfer_count <= xfer_count + len_t'(1);
          rem <= rem - len_t'(1);
          src_cur <= desc ? src_cur - addr_t'(1) : src_cur + addr_t'(1);
          dst_cur <= desc ? dst_cur - addr_t'(1) : dst_cur + addr_t'(1);
        end
        default: ;
      endcase
    end
  assign busy = (state == ST_READ) || (state == ST_WRITE) || (state == ST_FILL);
  assign done = state == ST_DONE;
  assign mem_read_enable = state == ST_READ;
  // abort kills the in-flight word combinationally so it never reaches memory
  assign mem_write_enable = ((state == ST_WRITE) || (state == ST_FILL)) && !abort;
  assign mem_address = mem_read_enable ? src_cur : mem_write_enable ? dst_cur : '0;
  assign mem_write_data = !mem_write_enable ? '0 : (state == ST_FILL) ? fill_reg : buffer;
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: scoreboard bench with a combinational-read memory model on the datamem port.
module tb_mem_copy_engine;
  logic clk = 0, reset = 0, start = 0, mode = 0, abort = 0;
  logic [15:0] src_addr = 0, dst_addr = 0, length = 0, fill_value = 0;
  logic busy, done, aborted, mem_read_enable, mem_write_enable;
  logic [15:0] xfer_count, mem_address, mem_write_data, mem_read_data;
  logic [15:0] mem [0:65535];
  int total = 0, bad = 0, cyc = 0, s_cyc = 0, done_seen = 0, busy_cnt = 0;
  typedef struct {int cnt; logic ab; int lat; int bz;} done_t;
  logic [15:0] rdq[$];
  logic [31:0] wrq[$];
  done_t dnq[$];

  mem_copy_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_value(fill_value), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .xfer_count(xfer_count),
    .mem_address(mem_address), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_write_enable) mem[mem_address] <= mem_write_data;
  assign mem_read_data = mem[mem_address];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    done_t d;
    if (!reset) busy_cnt = 0;
    if (mem_read_enable) begin
      if (rdq.size() == 0) begin
        total++; bad++;
        $display("FAIL read: got unexpected read at %0h want none", mem_address);
      end else chk("read addr", {47'b0, mem_write_enable, mem_address}, {48'b0, rdq.pop_front()});
    end
    if (mem_write_enable) begin
      if (wrq.size() == 0) begin
        total++; bad++;
        $display("FAIL write: got unexpected write %0h<=%0h want none", mem_address, mem_write_data);
      end else chk("write", {31'b0, mem_read_enable, mem_address, mem_write_data}, {32'b0, wrq.pop_front()});
    end
    if (!mem_read_enable && !mem_write_enable) chk("idle bus", {32'b0, mem_address, mem_write_data}, 64'h0);
    if (busy) busy_cnt++;
    if (done) begin
      if (dnq.size() == 0) begin
        total++; bad++;
        $display("FAIL done: got unexpected done want none");
      end else begin
        d = dnq.pop_front();
        chk("xfer_count", 64'(xfer_count), 64'(d.cnt));
        chk("aborted", 64'(aborted), 64'(d.ab));
        chk("latency", 64'(cyc - s_cyc + 1), 64'(d.lat));
        chk("busy cycles", 64'(busy_cnt), 64'(d.bz));
      end
      busy_cnt = 0;
      done_seen++;
    end
  end

  task automatic exp_rd(input logic [15:0] a);
    rdq.push_back(a);
  endtask
  task automatic exp_wr(input logic [15:0] a, input logic [15:0] v);
    wrq.push_back({a, v});
  endtask
  task automatic exp_done(input int cnt, input logic ab, input int lat, input int bz);
    done_t d;
    d.cnt = cnt; d.ab = ab; d.lat = lat; d.bz = bz;
    dnq.push_back(d);
  endtask
  task automatic go(input logic m, input logic [15:0] s, input logic [15:0] d, input logic [15:0] n, input logic [15:0] f);
    @(negedge clk);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f; start = 1;
    @(posedge clk); #1;
    start = 0;
    s_cyc = cyc;
  endtask
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_done(input int snap);
    for (int i = 0; i < 200 && done_seen == snap; i++) begin @(negedge clk); #1; end
    if (done_seen == snap) begin
      total++; bad++;
      $display("FAIL done timeout: got no done want done");
    end
  endtask
  function automatic logic [52:0] outs();
    return {busy, done, aborted, xfer_count, mem_read_enable, mem_write_enable, mem_address, mem_write_data};
  endfunction

  initial begin
    int snap;
    tick(2);
    chk("reset state", 64'(outs()), 64'h0);
    @(negedge clk) reset = 1;
    // ascending copy
    for (int i = 0; i < 4; i++) begin
      mem[16+i] <= 16'(16'hA1 + i);
      mem[256+i] <= 16'h0;
      exp_rd(16'(16+i));
      exp_wr(16'(256+i), 16'(16'hA1 + i));
    end
    exp_done(4, 0, 9, 8);
    snap = done_seen;
    go(0, 16'h0010, 16'h0100, 4, 0);
    wait_done(snap);
    for (int i = 0; i < 4; i++) chk("copy dst", 64'(mem[256+i]), 64'(16'hA1 + i));
    // overlapping copy walks downwards
    mem[10] <= 1; mem[11] <= 2; mem[12] <= 3; mem[13] <= 0;
    exp_rd(12); exp_rd(11); exp_rd(10);
    exp_wr(13, 3); exp_wr(12, 2); exp_wr(11, 1);
    exp_done(3, 0, 7, 6);
    snap = done_seen;
    go(0, 10, 11, 3, 0);
    wait_done(snap);
    for (int i = 0; i < 4; i++) chk("overlap mem", 64'(mem[10+i]), 64'(i == 0 ? 1 : i));
    // fill wrapping the address space
    exp_wr(16'hFFFE, 16'hBEEF); exp_wr(16'hFFFF, 16'hBEEF);
    exp_wr(16'h0000, 16'hBEEF); exp_wr(16'h0001, 16'hBEEF);
    exp_done(4, 0, 5, 4);
    snap = done_seen;
    go(1, 0, 16'hFFFE, 4, 16'hBEEF);
    wait_done(snap);
    // zero length, both modes
    exp_done(0, 0, 1, 0);
    snap = done_seen;
    go(0, 5, 6, 0, 0);
    wait_done(snap);
    exp_done(0, 0, 1, 0);
    snap = done_seen;
    go(1, 0, 7, 0, 16'h55);
    wait_done(snap);
    // abort during third write; a start while busy must be ignored
    for (int i = 0; i < 8; i++) begin
      mem[16'h200+i] <= 16'(16'h5000 + i);
      mem[16'h300+i] <= 16'h7777;
    end
    exp_rd(16'h200); exp_rd(16'h201); exp_rd(16'h202);
    exp_wr(16'h300, 16'h5000); exp_wr(16'h301, 16'h5001);
    exp_done(2, 1, 7, 6);
    snap = done_seen;
    go(0, 16'h0200, 16'h0300, 8, 0);
    tick(2);
    start = 1; mode = 1; dst_addr = 16'h0900; length = 3; fill_value = 16'hDEAD;
    tick(1);
    start = 0;
    tick(2);
    abort = 1;
    tick(1);
    abort = 0;
    wait_done(snap);
    chk("aborted held", 64'(aborted), 64'h1);
    chk("count held", 64'(xfer_count), 64'h2);
    for (int i = 0; i < 8; i++) chk("abort dst", 64'(mem[16'h300+i]), 64'(i < 2 ? 16'h5000 + i : 16'h7777));
    // async reset mid-copy
    for (int i = 0; i < 4; i++) mem[16'h400+i] <= 16'h0;
    exp_rd(16'h10); exp_rd(16'h11);
    exp_wr(16'h400, 16'hA1);
    go(0, 16'h0010, 16'h0400, 4, 0);
    tick(2);
    reset = 0;
    #1;
    chk("async reset", 64'(outs()), 64'h0);
    rdq.delete();
    wrq.delete();
    tick(2);
    @(negedge clk) reset = 1;
    #1;
    chk("after reset", 64'(outs()), 64'h0);
    chk("reset no write", 64'(mem[16'h401]), 64'h0);
    exp_rd(16'h10); exp_rd(16'h11);
    exp_wr(16'h600, 16'hA1); exp_wr(16'h601, 16'hA2);
    exp_done(2, 0, 5, 4);
    snap = done_seen;
    go(0, 16'h0010, 16'h0600, 2, 0);
    wait_done(snap);
    chk("fresh copy", {32'b0, mem[16'h600], mem[16'h601]}, 64'h00A100A2);
    chk("leftover", 64'(rdq.size() + wrq.size() + dnq.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
